// File: rtl/qspi_psram_ctrl.sv
// QSPI PSRAM initiator: turns single-word core-bus requests into quad-mode
// PSRAM transactions ('h35 once after reset, then 'hEB read / 'h38 write).
// SCK runs at clk/2. Every output is registered and updated on entry to the
// SCK low phase. Read nibbles are sampled on the clk edge that ends the high
// phase.
module qspi_psram_ctrl #(
    parameter int DUMMY_RD = 6,
    parameter int DUMMY_WR = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [23:0] req_adr_i,
    input  logic [1:0]  req_len_i,
    input  logic [31:0] req_wdat_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdat_o,
    output logic        init_done_o,
    output logic        sck_o,
    output logic        cs_on,
    output logic [3:0]  sdo_o,
    output logic [3:0]  sdoe_o,
    input  logic [3:0]  sdi_i
);
    localparam logic [2:0] S_INIT  = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_CMD   = 3'd2;
    localparam logic [2:0] S_ADR   = 3'd3;
    localparam logic [2:0] S_DUMMY = 3'd4;
    localparam logic [2:0] S_WDATA = 3'd5;
    localparam logic [2:0] S_RDATA = 3'd6;
    localparam logic [2:0] S_TRAIL = 3'd7;

    localparam logic [7:0] CMD_QPI = 8'h35;
    localparam logic [7:0] CMD_RD  = 8'hEB;
    localparam logic [7:0] CMD_WR  = 8'h38;

    logic [2:0]  state_reg;
    logic [7:0]  cnt_reg;      // SCK index within the current state
    logic        fresh_reg;    // first step after reset: enter INIT without advancing
    logic        we_reg;
    logic [1:0]  len_reg;
    logic [23:0] adr_reg;
    logic [31:0] wdat_reg;
    logic [31:0] rbuf_reg;

    logic [7:0]  dummy_len;
    logic [2:0]  data_state;
    logic [7:0]  seg_len;
    logic [2:0]  seg_next;
    logic        seg_last;
    logic [2:0]  ent_state;
    logic [7:0]  ent_cnt;
    logic        ent_cs;
    logic [3:0]  ent_sdo;
    logic [3:0]  ent_sdoe;
    logic [7:0]  cmd_byte;
    logic [4:0]  ad_base;
    logic [4:0]  wd_base;
    logic [4:0]  rd_base;
    logic [31:0] rbuf_next;

    assign dummy_len  = we_reg ? 8'(DUMMY_WR) : 8'(DUMMY_RD);
    assign data_state = we_reg ? S_WDATA : S_RDATA;
    // The command is chosen on the accept edge, before we_reg is loaded.
    assign cmd_byte   = ((state_reg == S_IDLE) ? req_we_i : we_reg) ? CMD_WR : CMD_RD;
    // Address goes out high nibble first; data bytes go out in address order,
    // each high nibble first.
    assign ad_base    = 5'd20 - {ent_cnt[2:0], 2'b00};
    assign wd_base    = {ent_cnt[2:1], ~ent_cnt[0], 2'b00};
    assign rd_base    = {cnt_reg[2:1], ~cnt_reg[0], 2'b00};

    // Length in SCK periods of the current state, and the state that follows it.
    always_comb begin
        seg_len  = 8'd1;
        seg_next = S_IDLE;
        case (state_reg)
            S_INIT:  begin seg_len = 8'd8; seg_next = S_TRAIL; end
            S_CMD:   begin seg_len = 8'd8; seg_next = S_ADR; end
            S_ADR:   begin
                seg_len  = 8'd6;
                seg_next = (dummy_len == 8'd0) ? data_state : S_DUMMY;
            end
            S_DUMMY: begin seg_len = dummy_len; seg_next = data_state; end
            S_WDATA, S_RDATA: begin
                seg_len  = {5'd0, len_reg, 1'b0} + 8'd2;
                seg_next = S_TRAIL;
            end
            default: begin seg_len = 8'd1; seg_next = S_IDLE; end
        endcase
    end

    assign seg_last = (cnt_reg == seg_len - 8'd1);

    // State and SCK index to enter on the next low phase.
    always_comb begin
        ent_state = state_reg;
        ent_cnt   = cnt_reg + 8'd1;
        if (state_reg == S_IDLE) begin
            ent_state = S_CMD;
            ent_cnt   = 8'd0;
        end else if (fresh_reg) begin
            ent_cnt   = 8'd0;
        end else if (seg_last) begin
            ent_state = seg_next;
            ent_cnt   = 8'd0;
        end
    end

    // Pin values presented during the low phase being entered.
    always_comb begin
        ent_cs   = 1'b0;
        ent_sdo  = 4'h0;
        ent_sdoe = 4'h0;
        case (ent_state)
            S_INIT:  begin ent_sdo = {3'b000, CMD_QPI[3'd7 - ent_cnt[2:0]]}; ent_sdoe = 4'b0001; end
            S_CMD:   begin ent_sdo = {3'b000, cmd_byte[3'd7 - ent_cnt[2:0]]}; ent_sdoe = 4'b0001; end
            S_ADR:   begin ent_sdo = adr_reg[ad_base +: 4]; ent_sdoe = 4'b1111; end
            S_WDATA: begin ent_sdo = wdat_reg[wd_base +: 4]; ent_sdoe = 4'b1111; end
            S_DUMMY, S_RDATA: ent_cs = 1'b0;
            default: ent_cs = 1'b1;
        endcase
    end

    // Read buffer with the nibble sampled at the end of this high phase merged in.
    always_comb begin
        rbuf_next = rbuf_reg;
        rbuf_next[rd_base +: 4] = sdi_i;
    end

    // Sequencer: accept in IDLE, otherwise alternate SCK low/high phases.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg   <= S_INIT;
            cnt_reg     <= 8'd0;
            fresh_reg   <= 1'b1;
            we_reg      <= 1'b0;
            len_reg     <= 2'd0;
            adr_reg     <= 24'd0;
            wdat_reg    <= 32'd0;
            rbuf_reg    <= 32'd0;
            sck_o       <= 1'b0;
            cs_on       <= 1'b1;
            sdo_o       <= 4'h0;
            sdoe_o      <= 4'h0;
            req_ready_o <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_rdat_o  <= 32'd0;
            init_done_o <= 1'b0;
        end else begin
            rsp_valid_o <= 1'b0;
            if (state_reg == S_IDLE) begin
                if (req_valid_i && req_ready_o) begin
                    we_reg      <= req_we_i;
                    len_reg     <= req_len_i;
                    adr_reg     <= req_adr_i;
                    wdat_reg    <= req_wdat_i;
                    rbuf_reg    <= 32'd0;
                    req_ready_o <= 1'b0;
                    state_reg   <= ent_state;
                    cnt_reg     <= ent_cnt;
                    cs_on       <= ent_cs;
                    sdo_o       <= ent_sdo;
                    sdoe_o      <= ent_sdoe;
                end
            end else if (fresh_reg || sck_o) begin
                fresh_reg <= 1'b0;
                sck_o     <= 1'b0;
                state_reg <= ent_state;
                cnt_reg   <= ent_cnt;
                cs_on     <= ent_cs;
                sdo_o     <= ent_sdo;
                sdoe_o    <= ent_sdoe;
                if (!fresh_reg) begin
                    if (state_reg == S_RDATA) begin
                        rbuf_reg <= rbuf_next;
                        if (seg_last) begin
                            rsp_rdat_o <= rbuf_next;
                        end
                    end
                    if ((state_reg == S_WDATA || state_reg == S_RDATA) && ent_state == S_TRAIL) begin
                        rsp_valid_o <= 1'b1;
                    end
                    if (ent_state == S_IDLE) begin
                        init_done_o <= 1'b1;
                        req_ready_o <= 1'b1;
                    end
                end
            end else begin
                sck_o <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_qspi_psram_ctrl.sv
// Bench for qspi_psram_ctrl: a behavioural quad PSRAM drives sdi and stores
// writes. The driver pushes the expected response per accepted request.
// A monitor pops and checks the response on every rsp_valid pulse.
module tb_qspi_psram_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [23:0] req_adr;
    logic [1:0]  req_len;
    logic [31:0] req_wdat, rsp_rdat;
    logic        rsp_valid, init_done, sck, cs_n;
    logic [3:0]  sdo, sdoe, sdi;

    always #5 clk = ~clk;

    qspi_psram_ctrl #(.DUMMY_RD(6), .DUMMY_WR(0)) dut (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_we_i(req_we), .req_adr_i(req_adr), .req_len_i(req_len), .req_wdat_i(req_wdat),
        .rsp_valid_o(rsp_valid), .rsp_rdat_o(rsp_rdat), .init_done_o(init_done),
        .sck_o(sck), .cs_on(cs_n), .sdo_o(sdo), .sdoe_o(sdoe), .sdi_i(sdi)
    );

    int cyc = 0;
    int n_vec = 0;
    int n_bad = 0;

    // Free-running cycle counter used for latency measurement.
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        n_vec++;
        n_bad++;
        $display("FAIL %s: %s", name, what);
    endtask

    typedef struct {
        logic [31:0] rdat;
        int          lat;
        int          acc;
    } exp_t;
    exp_t sb[$];

    // ---------------- PSRAM model ----------------
    int          bitn = 0, last_bits = 0, mk = 0;
    logic [7:0]  mcmd = 8'h00, last_cmd = 8'h00;
    logic [23:0] madr = 24'h0, ma = 24'h0;
    bit   [7:0]  mb;
    bit   [7:0]  mem [int];
    int          sdoe_viol = 0, cs_low = 0, last_cs_low = 0, trail_cnt = 0;
    int          ready_viol = 0, overlap = 0;

    // Samples and updates on SCK rising while selected; counts SCK pulses with CS high.
    always @(posedge sck) begin
        if (cs_n === 1'b0) begin
            if (bitn < 8) begin
                if (sdoe !== 4'b0001) sdoe_viol++;
                mcmd = {mcmd[6:0], sdo[0]};
            end else if (bitn < 14) begin
                if (sdoe !== 4'b1111) sdoe_viol++;
                madr = {madr[19:0], sdo};
            end else if (mcmd == 8'h38) begin
                if (sdoe !== 4'b1111) sdoe_viol++;
                mk = bitn - 14;
                ma = madr + 24'(mk / 2);
                mb = mem.exists(int'(ma)) ? mem[int'(ma)] : 8'h00;
                if (mk % 2 == 0) mb[7:4] = sdo; else mb[3:0] = sdo;
                mem[int'(ma)] = mb;
            end else if (mcmd == 8'hEB) begin
                if (sdoe !== 4'b0000) sdoe_viol++;
                if (bitn >= 20) begin
                    mk = bitn - 20;
                    ma = madr + 24'(mk / 2);
                    mb = mem.exists(int'(ma)) ? mem[int'(ma)] : 8'h00;
                    sdi = (mk % 2 == 0) ? mb[7:4] : mb[3:0];
                end
            end
            bitn++;
        end else if (cs_n === 1'b1) begin
            trail_cnt++;
        end
    end

    // End of a chip-select frame: record what the frame carried.
    always @(posedge cs_n) begin
        last_cmd    = mcmd;
        last_bits   = bitn;
        last_cs_low = cs_low;
        bitn        = 0;
        cs_low      = 0;
    end

    // CS-low duration and ready-while-busy watch.
    always @(negedge clk) begin
        if (cs_n === 1'b0) cs_low++;
        if (!rst && req_ready === 1'b1 && cs_n === 1'b0) ready_viol++;
    end

    // Monitor: every response pops one expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                fail_now("unexpected_rsp", "rsp_valid_o=1 with nothing outstanding, required 0");
            end else begin
                e = sb.pop_front();
                chk("rsp_latency", cyc - e.acc + 1, e.lat);
                chk("rsp_rdat", rsp_rdat, e.rdat);
            end
        end
    end

    // Issue one request (count accepts with valid held), then wait for all responses.
    task automatic do_req(input logic we, input logic [23:0] adr, input logic [1:0] len,
                          input logic [31:0] wdat, input logic [31:0] exp_rdat,
                          input int exp_lat, input int count);
        int   got = 0;
        int   w = 0;
        exp_t e;
        @(negedge clk);
        req_we = we; req_adr = adr; req_len = len; req_wdat = wdat; req_valid = 1'b1;
        while (got < count && w < 400) begin
            if (req_ready === 1'b1) begin
                if (sb.size() != 0) overlap++;
                e.rdat = exp_rdat; e.lat = exp_lat; e.acc = cyc + 1;
                sb.push_back(e);
                got++;
            end
            @(negedge clk);
            w++;
        end
        req_valid = 1'b0;
        if (got < count) fail_now("accept_timeout", "req_ready_o never rose, required 1");
        w = 0;
        while (sb.size() > 0 && w < 400) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() > 0) begin
            fail_now("rsp_timeout", "rsp_valid_o never pulsed, required 1");
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    // Wait for init_done_o after reset release; expect it 19 clk later.
    task automatic wait_init();
        int w = 0;
        int start = cyc;
        while (init_done !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("init_latency", cyc - start, 19);
        chk("init_ready", {31'd0, req_ready}, 32'd1);
        chk("init_cmd", {24'd0, last_cmd}, 32'h35);
    endtask

    initial begin
        int w;
        int trail_before;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_adr = '0; req_len = '0;
        req_wdat = '0; sdi = 4'h0;
        repeat (3) @(negedge clk);
        chk("rst_sck", {31'd0, sck}, 32'd0);
        chk("rst_cs", {31'd0, cs_n}, 32'd1);
        chk("rst_sdo", {28'd0, sdo}, 32'd0);
        chk("rst_sdoe", {28'd0, sdoe}, 32'd0);
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rdat", rsp_rdat, 32'd0);
        chk("rst_init_done", {31'd0, init_done}, 32'd0);
        rst = 1'b0;
        wait_init();
        chk("init_cs_low", last_cs_low, 16);
        chk("init_bits", last_bits, 8);
        chk("init_trail", trail_cnt, 1);

        // Write 4 bytes at 0x10.
        do_req(1'b1, 24'h000010, 2'd3, 32'hDDCCBBAA, 32'h0, 45, 1);
        chk("w1_cmd", {24'd0, last_cmd}, 32'h38);
        chk("w1_adr", {8'd0, madr}, 32'h10);
        chk("w1_cs_low", last_cs_low, 44);
        chk("w1_trail", trail_cnt, 2);
        chk("w1_mem10", {24'd0, mem[32'h10]}, 32'hAA);
        chk("w1_mem11", {24'd0, mem[32'h11]}, 32'hBB);
        chk("w1_mem12", {24'd0, mem[32'h12]}, 32'hCC);
        chk("w1_mem13", {24'd0, mem[32'h13]}, 32'hDD);

        // Read them back.
        do_req(1'b0, 24'h000010, 2'd3, 32'h0, 32'hDDCCBBAA, 57, 1);
        chk("r2_cmd", {24'd0, last_cmd}, 32'hEB);
        chk("r2_sdoe", sdoe_viol, 0);

        // Single byte at the top of the address space.
        mem[32'hFFFFFF] = 8'h5A;
        do_req(1'b0, 24'hFFFFFF, 2'd0, 32'h0, 32'h0000005A, 45, 1);

        // Two-byte write; upper wdat bytes are ignored, rdat holds the last read.
        do_req(1'b1, 24'hABCDEF, 2'd1, 32'hEEEE3412, 32'h0000005A, 37, 1);
        chk("w4_memef", {24'd0, mem[32'hABCDEF]}, 32'h12);
        chk("w4_memf0", {24'd0, mem[32'hABCDF0]}, 32'h34);
        do_req(1'b0, 24'hABCDEF, 2'd1, 32'h0, 32'h00003412, 49, 1);
        do_req(1'b0, 24'h000010, 2'd1, 32'h0, 32'h0000BBAA, 49, 1);

        // Write crossing the 24-bit wrap, then read back.
        do_req(1'b1, 24'hFFFFFF, 2'd1, 32'h00002211, 32'h0000BBAA, 37, 1);
        chk("w7_memff", {24'd0, mem[32'hFFFFFF]}, 32'h11);
        chk("w7_mem00", {24'd0, mem[32'h0]}, 32'h22);
        do_req(1'b0, 24'hFFFFFF, 2'd1, 32'h0, 32'h00002211, 49, 1);

        // Valid held high across three transactions.
        do_req(1'b0, 24'h000010, 2'd0, 32'h0, 32'h000000AA, 45, 3);
        chk("held_overlap", overlap, 0);
        chk("held_ready_busy", ready_viol, 0);

        // Reset in the middle of RDATA.
        @(negedge clk);
        req_we = 1'b0; req_adr = 24'h000010; req_len = 2'd3; req_valid = 1'b1;
        w = 0;
        while (req_ready !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (req_ready !== 1'b1) fail_now("abort_accept", "req_ready_o never rose, required 1");
        @(negedge clk);
        req_valid = 1'b0;
        repeat (44) @(negedge clk);
        trail_before = trail_cnt;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_cs", {31'd0, cs_n}, 32'd1);
        chk("abort_sck", {31'd0, sck}, 32'd0);
        chk("abort_sdoe", {28'd0, sdoe}, 32'd0);
        chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("abort_no_trail", trail_cnt, trail_before);
        chk("abort_frame_cmd", {24'd0, last_cmd}, 32'hEB);
        @(negedge clk);
        rst = 1'b0;
        wait_init();
        do_req(1'b0, 24'h000010, 2'd3, 32'h0, 32'hDDCCBBAA, 57, 1);
        chk("final_sdoe", sdoe_viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Global time limit.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at time limit, required finish");
        $fatal(1, "watchdog");
    end
endmodule
